wb_pipe: RTL

Parametrised post-execute writeback pipeline. It replaces the fixed ex_mem/mem_wb register pair with DEPTH stages that carry (wreg, wd, wdata) from the EX output to the regfile write port. Adds per-stage stall, global flush and RD_PORTS combinational forwarding ports. ID reads see the youngest in-flight value instead of stale regfile data.

---
 rtl/wb_pipe_pkg.sv | 32 +++
 rtl/wb_pipe_stage.sv | 63 ++++++
 rtl/wb_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_pipe_pkg.sv
// Shared definitions for the writeback pipeline: write-enable encodings and
// the per-stage update decision used by every register stage.
package wb_pipe_pkg;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Bubble contents: WriteDisable with zero address and zero data.
  localparam logic WbStageBubbleWreg = WriteDisable;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } stage_op_e;

  // First matching case wins: flush beats hold, and a held upstream stage
  // leaves a bubble behind in this one.
  function automatic stage_op_e stage_op(input logic flush,
                                         input logic hold,
                                         input logic up_hold);
    if (flush) begin
      return ST_BUBBLE;
    end else if (hold) begin
      return ST_HOLD;
    end else if (up_hold) begin
      return ST_BUBBLE;
    end
    return ST_LOAD;
  endfunction

endpackage

// File: rtl/wb_pipe_stage.sv
// One writeback pipeline register stage carrying (wreg, wd, wdata), with
// hold, bubble insertion and flush.
module wb_pipe_stage
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              prev_stall_i,
  input  logic              flush_i,
  input  logic              prev_wreg_i,
  input  logic [ADDR_W-1:0] prev_wd_i,
  input  logic [DATA_W-1:0] prev_wdata_i,
  output logic              wreg_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic [DATA_W-1:0] wdata_o
);

  stage_op_e         op;
  logic              wreg_d, wreg_q;
  logic [ADDR_W-1:0] wd_d, wd_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;

  always_comb begin
    op      = stage_op(flush_i, stall_i, prev_stall_i);
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    wdata_d = wdata_q;
    case (op)
      ST_LOAD: begin
        wreg_d  = prev_wreg_i;
        wd_d    = prev_wd_i;
        wdata_d = prev_wdata_i;
      end
      ST_BUBBLE: begin
        wreg_d  = WbStageBubbleWreg;
        wd_d    = '0;
        wdata_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q  <= WriteDisable;
      wd_q    <= '0;
      wdata_q <= '0;
    end else begin
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      wdata_q <= wdata_d;
    end
  end

  assign wreg_o  = wreg_q;
  assign wd_o    = wd_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/wb_pipe.sv
// Parametrised EX-to-regfile writeback pipeline with per-stage stall, global
// flush and youngest-first combinational forwarding to the ID read ports.
module wb_pipe
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH-1:0]             stall_i,
  input  logic                         flush_i,
  input  logic                         in_wreg_i,
  input  logic [ADDR_W-1:0]            in_wd_i,
  input  logic [DATA_W-1:0]            in_wdata_i,
  output logic                         wb_we_o,
  output logic [ADDR_W-1:0]            wb_waddr_o,
  output logic [DATA_W-1:0]            wb_wdata_o,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_data_i,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
  output logic [RD_PORTS-1:0]          rd_hit_o
);

  logic [DEPTH-1:0]             es;
  logic [DEPTH-1:0]             stg_wreg;
  logic [DEPTH-1:0][ADDR_W-1:0] stg_wd;
  logic [DEPTH-1:0][DATA_W-1:0] stg_wdata;

  // Stage k holds whenever it or any older stage is stalled.
  always_comb begin
    es = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      es[k] = |(stall_i >> k);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              prev_stall;
    logic              prev_wreg;
    logic [ADDR_W-1:0] prev_wd;
    logic [DATA_W-1:0] prev_wdata;

    if (k == 0) begin : g_head
      assign prev_stall = 1'b0;
      assign prev_wreg  = in_wreg_i;
      assign prev_wd    = in_wd_i;
      assign prev_wdata = in_wdata_i;
    end else begin : g_body
      assign prev_stall = es[k-1];
      assign prev_wreg  = stg_wreg[k-1];
      assign prev_wd    = stg_wd[k-1];
      assign prev_wdata = stg_wdata[k-1];
    end

    wb_pipe_stage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (es[k]),
      .prev_stall_i (prev_stall),
      .flush_i      (flush_i),
      .prev_wreg_i  (prev_wreg),
      .prev_wd_i    (prev_wd),
      .prev_wdata_i (prev_wdata),
      .wreg_o       (stg_wreg[k]),
      .wd_o         (stg_wd[k]),
      .wdata_o      (stg_wdata[k])
    );
  end

  assign wb_we_o    = stg_wreg[DEPTH-1];
  assign wb_waddr_o = stg_wd[DEPTH-1];
  assign wb_wdata_o = stg_wdata[DEPTH-1];

  // Candidates are scanned oldest first so the youngest match is written last.
  always_comb begin
    rd_data_o = rd_data_i;
    rd_hit_o  = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      logic [ADDR_W-1:0] addr;
      addr = rd_addr_i[p*ADDR_W +: ADDR_W];
      if (addr != '0) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (stg_wreg[DEPTH-1-i] && (stg_wd[DEPTH-1-i] == addr)) begin
            rd_data_o[p*DATA_W +: DATA_W] = stg_wdata[DEPTH-1-i];
            rd_hit_o[p]                   = 1'b1;
          end
        end
        if (in_wreg_i && (in_wd_i == addr)) begin
          rd_data_o[p*DATA_W +: DATA_W] = in_wdata_i;
          rd_hit_o[p]                   = 1'b1;
        end
      end
    end
  end

endmodule
